// File: rtl/enc_pkg.sv
// Shared types and constants for the one-hot scan encoder.
// ACT_HIGH/ACT_LOW select the active level of the captured request vector.
package enc_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } enc_state_t;

   localparam logic ACT_HIGH = 1'b1;
   localparam logic ACT_LOW  = 1'b0;

endpackage

// File: rtl/lsb_prio_enc.sv
// Combinational lowest-set-bit priority encoder over a 2**OUT wide vector.
// o_found is low when the vector is all zeros (o_idx is then 0).
module lsb_prio_enc #(
   parameter int OUT = 4
) (
   input  logic [(1<<OUT)-1:0] i_vec,
   output logic [OUT-1:0]      o_idx,
   output logic                o_found
);

   localparam int IN = 1 << OUT;

   // Walking from the top down lets the lowest set bit win the last assignment
   always_comb begin
      o_idx   = '0;
      o_found = 1'b0;
      for (int i = IN - 1; i >= 0; i--) begin
         if (i_vec[i]) begin
            o_idx   = OUT'(i);
            o_found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/onehot_scan_enc.sv
// Sequential bit-vector-to-binary encoder: emits the index of every active
// request bit, lowest first, one beat per cycle over a valid/ready handshake.
module onehot_scan_enc
   import enc_pkg::*;
#(
   parameter int   OUT = 4,
   parameter logic ACT = ACT_HIGH
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [(1<<OUT)-1:0] in,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [OUT-1:0]      out,
   output logic                out_last,
   output logic                none,
   output logic                busy
);

   localparam int IN = 1 << OUT;

   enc_state_t      r_state;
   logic [IN-1:0]   r_pending;
   logic [OUT-1:0]  r_out;
   logic            r_last;
   logic            r_none;

   logic [IN-1:0]   w_inNorm;
   logic [OUT-1:0]  w_inIdx;
   logic            w_inFound;
   logic            w_inOneHot;
   logic [IN-1:0]   w_pendNext;
   logic [OUT-1:0]  w_nextIdx;
   logic            w_nextFound;
   logic            w_nextOneHot;

   // Internally a set bit always means "active", whatever the input polarity
   assign w_inNorm     = (ACT == ACT_HIGH) ? in : ~in;
   assign w_inOneHot   = (w_inNorm & (w_inNorm - IN'(1))) == '0;
   assign w_pendNext   = r_pending & (r_pending - IN'(1));
   assign w_nextOneHot = (w_pendNext & (w_pendNext - IN'(1))) == '0;

   lsb_prio_enc #(.OUT(OUT)) u_inEnc (
      .i_vec   (w_inNorm),
      .o_idx   (w_inIdx),
      .o_found (w_inFound)
   );

   lsb_prio_enc #(.OUT(OUT)) u_nextEnc (
      .i_vec   (w_pendNext),
      .o_idx   (w_nextIdx),
      .o_found (w_nextFound)
   );

   // Index and last flag are precomputed one beat ahead so every output is a flop
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= IDLE;
         r_pending <= '0;
         r_out     <= '0;
         r_last    <= 1'b0;
         r_none    <= 1'b0;
      end else begin
         r_none <= 1'b0;
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  if (w_inFound) begin
                     r_state   <= SCAN;
                     r_pending <= w_inNorm;
                     r_out     <= w_inIdx;
                     r_last    <= w_inOneHot;
                  end else begin
                     r_none <= 1'b1;
                  end
               end
            end
            SCAN: begin
               if (out_ready) begin
                  r_pending <= w_pendNext;
                  r_out     <= w_nextIdx;
                  r_last    <= w_nextFound && w_nextOneHot;
                  if (!w_nextFound) begin
                     r_state <= IDLE;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign in_ready  = (r_state == IDLE);
   assign out_valid = (r_state == SCAN);
   assign busy      = (r_state == SCAN);
   assign out       = r_out;
   assign out_last  = r_last;
   assign none      = r_none;

endmodule

// File: tb/tb_onehot_scan_enc.sv
// Self-checking bench for onehot_scan_enc: table-driven vectors with a beat
// scoreboard, plus hand-written backpressure, overlap, reset and polarity cases.
module tb_onehot_scan_enc;
   import enc_pkg::*;

   typedef struct {
      logic [3:0] idx;
      logic       last;
   } beat_t;

   typedef struct {
      logic [15:0] vec;
      int          beats;
   } vec_t;

   logic        clock = 1'b0;
   logic        reset;
   logic        inValid, inReady, outValid, outReady, outLast, none, busy;
   logic [15:0] inVec;
   logic [3:0]  outIdx;
   logic        loInValid, loInReady, loOutValid, loOutReady, loOutLast, loNone, loBusy;
   logic [15:0] loInVec;
   logic [3:0]  loOutIdx;

   beat_t sbQueue[$];
   vec_t  vecTable[9];
   int    compareCount  = 0;
   int    mismatchCount = 0;

   always #5 clock = ~clock;

   onehot_scan_enc #(.OUT(4), .ACT(ACT_HIGH)) dutHigh (
      .clk(clock), .reset(reset), .in_valid(inValid), .in_ready(inReady), .in(inVec),
      .out_valid(outValid), .out_ready(outReady), .out(outIdx), .out_last(outLast),
      .none(none), .busy(busy)
   );

   onehot_scan_enc #(.OUT(4), .ACT(ACT_LOW)) dutLow (
      .clk(clock), .reset(reset), .in_valid(loInValid), .in_ready(loInReady), .in(loInVec),
      .out_valid(loOutValid), .out_ready(loOutReady), .out(loOutIdx), .out_last(loOutLast),
      .none(loNone), .busy(loBusy)
   );

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
      compareCount++;
      if (actual !== required) begin
         mismatchCount++;
         $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, actual, required, $time);
      end
   endtask

   // Reference model: one beat per set bit, ascending, last on the final one
   task automatic pushExpected(input logic [15:0] vec);
      int remaining = 0;
      beat_t b;
      for (int i = 0; i < 16; i++) if (vec[i]) remaining++;
      for (int i = 0; i < 16; i++) begin
         if (vec[i]) begin
            b.idx  = 4'(i);
            b.last = (remaining == 1);
            sbQueue.push_back(b);
            remaining--;
         end
      end
   endtask

   task automatic waitReady();
      bit seen = 0;
      for (int n = 0; n < 100; n++) begin
         @(posedge clock); #1;
         if (inReady) begin
            seen = 1;
            break;
         end
      end
      checkOutput("waitInReady", 32'(seen), 32'd1);
   endtask

   task automatic applyStimulus(input logic [15:0] vec);
      waitReady();
      inValid = 1'b1;
      inVec   = vec;
      pushExpected(vec);
      @(posedge clock); #1;
      inValid = 1'b0;
   endtask

   // First valid must appear on the cycle right after acceptance
   task automatic waitBeats(input int beats);
      int cycles = 0;
      for (int n = 0; n < 100; n++) begin
         @(negedge clock);
         if (outValid) cycles++;
         else break;
      end
      checkOutput("beatCycles", 32'(cycles), 32'(beats));
      checkOutput("inReadyAfterScan", 32'(inReady), 32'd1);
   endtask

   task automatic checkNonePulse();
      @(negedge clock);
      checkOutput("nonePulse", 32'(none), 32'd1);
      checkOutput("noBeatOnZero", 32'(outValid), 32'd0);
      checkOutput("inReadyOnZero", 32'(inReady), 32'd1);
      @(negedge clock);
      checkOutput("noneOneCycle", 32'(none), 32'd0);
      checkOutput("noBeatOnZeroLater", 32'(outValid), 32'd0);
   endtask

   // Scoreboard side: every accepted beat is popped and compared
   always @(negedge clock) begin
      beat_t exp;
      if (!reset && outValid) begin
         checkOutput("busyInScan", 32'(busy), 32'd1);
         checkOutput("inReadyInScan", 32'(inReady), 32'd0);
         if (outReady) begin
            if (sbQueue.size() == 0) begin
               compareCount++;
               mismatchCount++;
               $display("[TB] FAIL unexpectedBeat: actual=%0d required=no beat", outIdx);
            end else begin
               exp = sbQueue.pop_front();
               checkOutput("beatIdx", 32'(outIdx), 32'(exp.idx));
               checkOutput("beatLast", 32'(outLast), 32'(exp.last));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vecTable[0] = '{16'h8421, 4};
      vecTable[1] = '{16'h0000, 0};
      vecTable[2] = '{16'h0006, 2};
      vecTable[3] = '{16'h8000, 1};
      vecTable[4] = '{16'h0001, 1};
      vecTable[5] = '{16'hFFFF, 16};
      vecTable[6] = '{16'hAAAA, 8};
      vecTable[7] = '{16'h0000, 0};
      vecTable[8] = '{16'h1248, 4};

      reset      = 1'b1;
      inValid    = 1'b0;
      inVec      = '0;
      outReady   = 1'b1;
      loInValid  = 1'b0;
      loInVec    = 16'hFFFF;
      loOutReady = 1'b1;
      repeat (2) @(posedge clock);
      @(negedge clock);
      checkOutput("rstOutValid", 32'(outValid), 32'd0);
      checkOutput("rstOut", 32'(outIdx), 32'd0);
      checkOutput("rstOutLast", 32'(outLast), 32'd0);
      checkOutput("rstNone", 32'(none), 32'd0);
      checkOutput("rstBusy", 32'(busy), 32'd0);
      @(posedge clock); #1;
      reset = 1'b0;
      @(negedge clock);
      checkOutput("rstInReady", 32'(inReady), 32'd1);

      for (int t = 0; t < 9; t++) begin
         applyStimulus(vecTable[t].vec);
         if (vecTable[t].beats == 0) checkNonePulse();
         else waitBeats(vecTable[t].beats);
      end

      // Backpressure: index 1 must hold for four cycles before advancing
      outReady = 1'b0;
      applyStimulus(16'h0006);
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         checkOutput("holdValid", 32'(outValid), 32'd1);
         checkOutput("holdIdx", 32'(outIdx), 32'd1);
         checkOutput("holdLast", 32'(outLast), 32'd0);
         if (i == 2) begin
            @(posedge clock); #1;
            outReady = 1'b1;
         end
      end
      waitBeats(1);

      // A second vector held during SCAN is taken only once in_ready returns
      begin
         bit readySeen = 0;
         waitReady();
         inValid = 1'b1;
         inVec   = 16'h0003;
         pushExpected(16'h0003);
         @(posedge clock); #1;
         inVec = 16'h0100;
         pushExpected(16'h0100);
         for (int n = 0; n < 20; n++) begin
            @(posedge clock); #1;
            if (inReady) begin
               readySeen = 1;
               break;
            end
         end
         checkOutput("readyAfterFirstVec", 32'(readySeen), 32'd1);
         @(posedge clock); #1;
         inValid = 1'b0;
         waitBeats(1);
      end

      // Reset mid-scan drops the remaining beats
      applyStimulus(16'h8421);
      @(negedge clock);
      @(posedge clock); #1;
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      sbQueue.delete();
      @(negedge clock);
      checkOutput("midRstOutValid", 32'(outValid), 32'd0);
      checkOutput("midRstBusy", 32'(busy), 32'd0);
      checkOutput("midRstInReady", 32'(inReady), 32'd1);
      applyStimulus(16'h0001);
      waitBeats(1);

      // Active-low instance
      @(posedge clock); #1;
      loInValid = 1'b1;
      loInVec   = 16'hFFFE;
      @(posedge clock); #1;
      loInValid = 1'b0;
      @(negedge clock);
      checkOutput("lowValid", 32'(loOutValid), 32'd1);
      checkOutput("lowIdx", 32'(loOutIdx), 32'd0);
      checkOutput("lowLast", 32'(loOutLast), 32'd1);
      @(negedge clock);
      checkOutput("lowDone", 32'(loOutValid), 32'd0);
      checkOutput("lowInReady", 32'(loInReady), 32'd1);
      @(posedge clock); #1;
      loInValid = 1'b1;
      loInVec   = 16'h7FFF;
      @(posedge clock); #1;
      loInValid = 1'b0;
      @(negedge clock);
      checkOutput("lowIdx15", 32'(loOutIdx), 32'd15);
      checkOutput("lowLast15", 32'(loOutLast), 32'd1);
      @(posedge clock); #1;
      loInValid = 1'b1;
      loInVec   = 16'hFFFF;
      @(posedge clock); #1;
      loInValid = 1'b0;
      @(negedge clock);
      checkOutput("lowNone", 32'(loNone), 32'd1);
      checkOutput("lowNoBeat", 32'(loOutValid), 32'd0);

      repeat (2) @(negedge clock);
      checkOutput("queueEmpty", 32'(sbQueue.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule

// File: doc/onehot_scan_enc.md
Name: onehot_scan_enc

Overview:
Sequential bit-vector-to-binary encoder. It accepts an IN-bit request vector and emits the binary index of every active bit, lowest index first, one index per beat. Both sides use a valid/ready handshake. It is the return direction of the binary-to-one-hot decoder, used to serialise decoded grant and flag vectors back into indices for downstream logic.

Parameters:
OUT, 4, width of the emitted binary index
ACT, `High, active level of input vector bits (`High: 1 = active, `Low: 0 = active)
IN, 1 << OUT, input vector width (derived constant, never overridden)

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
in_valid  input  1  input vector valid
in_ready  output  1  block can accept a vector
in  input  IN  request vector, polarity per ACT
out_valid  output  1  index beat valid
out_ready  input  1  downstream accepts beat
out  output  OUT  binary index of the lowest pending active bit
out_last  output  1  current beat is the final index of the vector
none  output  1  one-cycle pulse: accepted vector had no active bits
busy  output  1  scan in progress (state SCAN)

Behaviour:
- Single clock, clk. Reset is synchronous and active-high, sampled on the rising clk edge.
- Reset values: state IDLE, pending = 0, out_valid 0, out 0, out_last 0, none 0, busy 0. in_ready is 1 from the first cycle after reset.
- Normalisation: captured vector = ACT ? in : ~in. Internally, 1 always means active.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - SCAN: in_ready=0, out_valid=1, busy=1.
- IDLE, on in_valid:
  - Normalised vector non-zero: load pending, go to SCAN.
  - Normalised vector zero: pulse none for exactly the next cycle, stay IDLE, produce no output beat.
- SCAN outputs:
  - out = index of the lowest set bit in pending.
  - out_last = 1 when pending has exactly one bit set.
- SCAN handshake: on out_valid & out_ready, clear that bit in pending. If out_last, go to IDLE; otherwise stay in SCAN and present the next index the following cycle.
- Latency: vector accepted at edge N gives first out_valid at cycle N+1.
- Throughput: one index per cycle while out_ready is held high. A vector with k active bits occupies k cycles in SCAN. in_ready rises the cycle after the last beat; there is no overlap of vectors.
- Backpressure: while out_valid & !out_ready, out and out_last hold stable and pending is unchanged.
- out, out_last, out_valid, busy and in_ready are functions of registered state only. There is no combinational path from in/in_valid/out_ready to any output.
- in_valid in SCAN is ignored and in is not sampled. The sender must hold the vector until in_ready.
- Reset mid-scan discards pending and the remaining beats. out_valid is 0 the cycle after reset, and no partial beat is emitted.
- Width rule: index values 0..IN-1 fit exactly in OUT bits; no truncation is possible.
- ACT polarity affects only input capture. Outputs are always active-high.

Decomposition:
- Package enc_pkg: enc_state_t enum {IDLE, SCAN}.
- `High/`Low/`Enable/`Disable come from stddef.vh; no new macros.
- Sub-module lsb_prio_enc (combinational, parameter OUT): takes an IN-bit vector and returns the index of the lowest set bit, plus a single-bit flag. The top level reuses it for out, and for zero detection on the normalised input.
- Everything else stays in onehot_scan_enc.

Test Plan:
- OUT=4, ACT=`High, in=16'h0000 with in_valid -> none=1 for one cycle, out_valid never 1, in_ready stays 1.
- in=16'h8421, out_ready held 1 -> out = 0,5,10,15 on 4 consecutive cycles; out_last=1 only on 15; in_ready=1 the cycle after.
- in=16'h0006, out_ready=0 for 3 cycles then 1 -> out=1 held stable for 4 cycles with out_last=0, then out=2 with out_last=1.
- ACT=`Low, in=16'hFFFE -> single beat out=0, out_last=1.
- in=16'h0003, then in=16'h0100 held with in_valid during SCAN -> beats 0, 1(last); second vector accepted only after in_ready rises -> beat 8(last).
- in=16'h8421, assert reset after the first beat (out=0) -> out_valid=0 and busy=0 the next cycle; then in=16'h0001 -> single beat out=0, out_last=1.
